fetch_stage: RTL

Instruction-fetch stage of the five-stage pipelined CPU. It owns the program counter and the IF/ID pipeline register, and it drives the instruction-memory read address. It applies hazard-unit stalls and branch flushes from the ID stage. It also keeps the cycle, stall and flush counters that the top-level bench prints every cycle.

---
 rtl/fetch_if.sv | 32 +++
 rtl/fetch_stage.sv | 90 +++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Signal bundle between the fetch stage and its surroundings (hazard unit,
// ID-stage branch resolution, instruction memory, IF/ID consumers).
interface fetch_if #(
    parameter int ADDR_W = 32
);
    logic              stall_i;
    logic              flush_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic [31:0]       imem_data_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [ADDR_W-1:0] pc_o;
    logic [ADDR_W-1:0] if_id_pc_o;
    logic [31:0]       if_id_instr_o;
    logic              if_id_valid_o;
    logic [31:0]       cycle_cnt_o;
    logic [31:0]       stall_cnt_o;
    logic [31:0]       flush_cnt_o;
    logic              oob_o;

    // master: the fetch stage itself; slave: everything around it.
    modport master (
        input  stall_i, flush_i, branch_target_i, imem_data_i,
        output imem_addr_o, pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o,
               cycle_cnt_o, stall_cnt_o, flush_cnt_o, oob_o
    );

    modport slave (
        output stall_i, flush_i, branch_target_i, imem_data_i,
        input  imem_addr_o, pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o,
               cycle_cnt_o, stall_cnt_o, flush_cnt_o, oob_o
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, stall/flush handling,
// out-of-range fetch detection and performance counters.
module fetch_stage #(
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int                 IMEM_DEPTH = 256
) (
    input logic     clk_i,
    input logic     start_i,
    fetch_if.master bus
);
    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(IMEM_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
    logic [31:0]       if_id_instr_q, if_id_instr_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic [31:0]       cycle_cnt_q, cycle_cnt_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;
    logic [31:0]       flush_cnt_q, flush_cnt_d;
    logic              oob_q, oob_d;
    logic              in_range;

    // Word index compared against depth; byte offset bits do not matter.
    assign in_range = ({2'b00, pc_q[ADDR_W-1:2]} < DEPTH_W);

    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        cycle_cnt_d   = cycle_cnt_q + 32'd1;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        oob_d         = oob_q;

        if (bus.flush_i) begin
            pc_d          = {bus.branch_target_i[ADDR_W-1:2], 2'b00};
            if_id_pc_d    = '0;
            if_id_instr_d = '0;
            if_id_valid_d = 1'b0;
            flush_cnt_d   = flush_cnt_q + 32'd1;
        end else if (bus.stall_i) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            pc_d       = pc_q + ADDR_W'(4);
            if_id_pc_d = pc_q;
            if (in_range) begin
                if_id_instr_d = bus.imem_data_i;
                if_id_valid_d = 1'b1;
            end else begin
                if_id_instr_d = '0;
                if_id_valid_d = 1'b0;
                oob_d         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= '0;
            if_id_valid_q <= 1'b0;
            cycle_cnt_q   <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            oob_q         <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            cycle_cnt_q   <= cycle_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            oob_q         <= oob_d;
        end
    end

    assign bus.imem_addr_o   = pc_q;
    assign bus.pc_o          = pc_q;
    assign bus.if_id_pc_o    = if_id_pc_q;
    assign bus.if_id_instr_o = if_id_instr_q;
    assign bus.if_id_valid_o = if_id_valid_q;
    assign bus.cycle_cnt_o   = cycle_cnt_q;
    assign bus.stall_cnt_o   = stall_cnt_q;
    assign bus.flush_cnt_o   = flush_cnt_q;
    assign bus.oob_o         = oob_q;
endmodule
